ac97_sdi_receiver: RTL and testbench
====================================

Name: ac97_sdi_receiver

Overview:
Deserializes the AC97 SDI stream (codec to controller), aligned to the AC97Sync frame strobe that our AC97 frame transmitter drives. Decodes slot 0 tag, slot 1 status address, slot 2 status data and slots 3/4 PCM capture samples. Presents them as registered words with one-cycle valid pulses. Register read-back and audio capture logic sit behind it.

Parameters:
PCM_WIDTH, 20, number of MSBs of slots 3/4 presented on PcmLeft/PcmRight (legal 1..20).
SYNC_HIGH_BITS, 16, number of bit periods AC97Sync must stay high at frame start.

Ports:
AC97BitClock  input  1  AC97 bit clock (12.288 MHz); sole clock, all logic on posedge.
Rst_n  input  1  asynchronous, active-low reset.
AC97SDI  input  1  serial data from codec, MSB-first per slot.
AC97Sync  input  1  frame sync as driven by our transmitter; rises at frame bit 0.
CodecReady  output  1  tag bit 15 of the last complete slot 0.
StatusAddr  output  7  slot 1 bits 18:12 (register index).
StatusData  output  16  slot 2 bits 19:4.
StatusValid  output  1  one-cycle pulse: new StatusAddr/StatusData.
PcmLeft  output  PCM_WIDTH  slot 3 bits 19:(20-PCM_WIDTH).
PcmRight  output  PCM_WIDTH  slot 4 bits 19:(20-PCM_WIDTH).
PcmValid  output  1  one-cycle pulse: at least one PCM word updated.
FrameDone  output  1  one-cycle pulse at the end of each complete frame.
SyncError  output  1  one-cycle pulse on a frame alignment violation.

Behaviour:
- Reset (Rst_n low, async): all outputs 0, shift register 0, bit counter 0, state HUNT, previous-sync register 0.
- Sampling: AC97SDI and AC97Sync are sampled on every posedge. A sync rising edge is sampled Sync=1 with previous sample 0. The SDI bit sampled on that edge is frame bit 0.
- Frame map (bit index): slot0 0-15; slot1 16-35; slot2 36-55; slot3 56-75; slot4 76-95; slots 5-12 96-255 (shifted, ignored).
- 20-bit shift register, MSB-first: shift = {shift[18:0], AC97SDI}. Slot captures use {shift[18:0], AC97SDI} on the edge that samples the last bit of the slot. Outputs are visible the following cycle.
- Tag (captured at bit 15, internal): ready=b15, v1=b14, v2=b13, v3=b12, v4=b11. CodecReady updates at bit 15.
- Bit 35: the slot 1 address is latched internally.
- Bit 55: if ready & v1 & v2, load StatusAddr from the latched address, load StatusData and pulse StatusValid. Otherwise both outputs hold and no pulse.
- Bit 95: PcmLeft loads only if ready & v3; PcmRight loads only if ready & v4. PcmValid pulses if either loaded.
- Bit 255: FrameDone pulses and the counter wraps to 0.
- State HUNT: counter idle at 0. A sync rising edge moves to RECEIVE with bit 0 consumed (counter becomes 1 next cycle). No error is flagged in HUNT.
- State RECEIVE: the counter increments every cycle, 8-bit wrap 255->0.
  - Sync must be 1 for bits 0..SYNC_HIGH_BITS-1. A sync low in that window pulses SyncError and goes to HUNT; the partial frame is dropped with no further valid pulses.
  - A sync rising edge at any bit other than 0 pulses SyncError and restarts the frame: that sample is bit 0, counter becomes 1, and the aborted frame gives no FrameDone.
  - At bit 0 after a wrap (post bit 255), sync not rising pulses SyncError and goes to HUNT.
- Back-to-back frames: a sync rise on the cycle after bit 255 continues in RECEIVE with no gap.
- Valid pulses never last more than one cycle. StatusValid, PcmValid and FrameDone can never coincide (distinct bit indices).
- Reset mid-frame: immediate clear as above; decoding resumes on the next sync rising edge.
- Latency: StatusValid 1 cycle after bit 55 is sampled; PcmValid 1 cycle after bit 95 is sampled.

Test Plan:
- Reset: assert Rst_n=0 mid-stream -> all outputs 0 asynchronously. Release with no sync -> outputs stay 0 and no pulses.
- Status frame: tag 0xE000, slot1 addr 0x26, slot2 data 0x000F -> CodecReady=1, StatusAddr=0x26, StatusData=0x000F, StatusValid high exactly one cycle after bit 55, FrameDone one cycle after bit 255.
- PCM frame: tag 0x9800, slot3 0x12345, slot4 0xABCDE, PCM_WIDTH=20 -> PcmLeft=0x12345, PcmRight=0xABCDE, single PcmValid pulse. Repeat with tag 0x9000 -> only PcmLeft updates, PcmRight holds 0xABCDE.
- Invalid status: tag 0xC000 (v2=0) with data 0x1234 -> no StatusValid, StatusData retains the previous 0x000F.
- Sync faults: sync drops at bit 8 -> SyncError pulse, HUNT, no valid pulses that frame. Early sync rise at bit 100 -> SyncError, new frame decoded correctly, no FrameDone for the aborted frame.
- Reset mid-frame at bit 40, then 3 back-to-back good frames -> outputs cleared, then 3 FrameDone pulses exactly 256 cycles apart and no SyncError.

Source files
------------

// File: rtl/ac97_sdi_receiver.sv
// ac97_sdi_receiver
//
// Deserializes the AC97 SDI stream (codec -> controller). Frames are aligned to
// the rising edge of AC97Sync as driven by our frame transmitter; the SDI bit
// sampled on that edge is frame bit 0. Slot 0 tag, slot 1 status address,
// slot 2 status data and slots 3/4 PCM capture samples are decoded into
// registered words with one-cycle valid pulses.
//
// Ports:
//   AC97BitClock  in   bit clock, all logic on posedge
//   Rst_n         in   asynchronous active-low reset
//   AC97SDI       in   serial data from codec, MSB-first per slot
//   AC97Sync      in   frame sync, rises at frame bit 0
//   CodecReady    out  tag bit 15 of the last complete slot 0
//   StatusAddr    out  slot 1 bits 18:12
//   StatusData    out  slot 2 bits 19:4
//   StatusValid   out  pulse: new StatusAddr/StatusData
//   PcmLeft       out  slot 3 MSBs
//   PcmRight      out  slot 4 MSBs
//   PcmValid      out  pulse: at least one PCM word updated
//   FrameDone     out  pulse at the end of each complete frame
//   SyncError     out  pulse on a frame alignment violation
module ac97_sdi_receiver #(
    parameter int unsigned PCM_WIDTH      = 20,
    parameter int unsigned SYNC_HIGH_BITS = 16
) (
    input  logic                 AC97BitClock,
    input  logic                 Rst_n,
    input  logic                 AC97SDI,
    input  logic                 AC97Sync,
    output logic                 CodecReady,
    output logic [6:0]           StatusAddr,
    output logic [15:0]          StatusData,
    output logic                 StatusValid,
    output logic [PCM_WIDTH-1:0] PcmLeft,
    output logic [PCM_WIDTH-1:0] PcmRight,
    output logic                 PcmValid,
    output logic                 FrameDone,
    output logic                 SyncError
);

    typedef enum logic [0:0] {StHunt, StReceive} state_e;

    localparam logic [8:0] SyncHighBits = 9'(SYNC_HIGH_BITS);

    state_e                 state_q, state_d;
    logic [7:0]             bit_cnt_q, bit_cnt_d;
    logic                   sync_prev_q;
    // Only 19 history bits are stored: the 20-bit capture word is always
    // completed by the live SDI sample, so the oldest bit is never read.
    logic [18:0]            shift_q;
    logic [19:0]            shift_next;
    logic [3:0]             tag_v_q, tag_v_d;      // {v1, v2, v3, v4}
    logic [6:0]             addr_lat_q, addr_lat_d;
    logic [PCM_WIDTH-1:0]   slot3_lat_q, slot3_lat_d;

    logic                   codec_ready_q, codec_ready_d;
    logic [6:0]             status_addr_q, status_addr_d;
    logic [15:0]            status_data_q, status_data_d;
    logic                   status_valid_q, status_valid_d;
    logic [PCM_WIDTH-1:0]   pcm_left_q, pcm_left_d;
    logic [PCM_WIDTH-1:0]   pcm_right_q, pcm_right_d;
    logic                   pcm_valid_q, pcm_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   sync_error_q, sync_error_d;

    logic                   sync_rise;
    logic                   in_sync_window;
    logic                   decode;

    assign sync_rise      = AC97Sync & ~sync_prev_q;
    assign shift_next     = {shift_q, AC97SDI};
    assign in_sync_window = {1'b0, bit_cnt_q} < SyncHighBits;

    // Frame alignment FSM and bit counter.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sync_error_d = 1'b0;
        decode       = 1'b0;

        case (state_q)
            StHunt: begin
                bit_cnt_d = 8'd0;
                if (sync_rise) begin
                    state_d   = StReceive;
                    bit_cnt_d = 8'd1;
                end
            end
            StReceive: begin
                bit_cnt_d = bit_cnt_q + 8'd1;  // 255 wraps to 0
                if (sync_rise) begin
                    // Restart on any rise; only a rise at bit 0 is legal.
                    sync_error_d = (bit_cnt_q != 8'd0);
                    bit_cnt_d    = 8'd1;
                end else if (bit_cnt_q == 8'd0) begin
                    // Post-wrap bit 0 without a new frame start.
                    sync_error_d = 1'b1;
                    state_d      = StHunt;
                    bit_cnt_d    = 8'd0;
                end else if (!AC97Sync && in_sync_window) begin
                    sync_error_d = 1'b1;
                    state_d      = StHunt;
                    bit_cnt_d    = 8'd0;
                end else begin
                    decode = 1'b1;
                end
            end
            default: begin
                state_d   = StHunt;
                bit_cnt_d = 8'd0;
            end
        endcase
    end

    // Slot decode: captures happen on the edge sampling the slot's last bit.
    always_comb begin
        tag_v_d        = tag_v_q;
        addr_lat_d     = addr_lat_q;
        slot3_lat_d    = slot3_lat_q;
        codec_ready_d  = codec_ready_q;
        status_addr_d  = status_addr_q;
        status_data_d  = status_data_q;
        status_valid_d = 1'b0;
        pcm_left_d     = pcm_left_q;
        pcm_right_d    = pcm_right_q;
        pcm_valid_d    = 1'b0;
        frame_done_d   = 1'b0;

        if (decode) begin
            case (bit_cnt_q)
                8'd15: begin
                    codec_ready_d = shift_next[15];
                    tag_v_d       = shift_next[14:11];
                end
                8'd35: addr_lat_d = shift_next[18:12];
                8'd55: begin
                    if (codec_ready_q && tag_v_q[3] && tag_v_q[2]) begin
                        status_addr_d  = addr_lat_q;
                        status_data_d  = shift_next[19:4];
                        status_valid_d = 1'b1;
                    end
                end
                8'd75: slot3_lat_d = shift_next[19 -: PCM_WIDTH];
                8'd95: begin
                    if (codec_ready_q && tag_v_q[1]) begin
                        pcm_left_d  = slot3_lat_q;
                        pcm_valid_d = 1'b1;
                    end
                    if (codec_ready_q && tag_v_q[0]) begin
                        pcm_right_d = shift_next[19 -: PCM_WIDTH];
                        pcm_valid_d = 1'b1;
                    end
                end
                8'd255: frame_done_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge AC97BitClock or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q        <= StHunt;
            bit_cnt_q      <= 8'd0;
            sync_prev_q    <= 1'b0;
            shift_q        <= '0;
            tag_v_q        <= '0;
            addr_lat_q     <= '0;
            slot3_lat_q    <= '0;
            codec_ready_q  <= 1'b0;
            status_addr_q  <= '0;
            status_data_q  <= '0;
            status_valid_q <= 1'b0;
            pcm_left_q     <= '0;
            pcm_right_q    <= '0;
            pcm_valid_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            sync_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            sync_prev_q    <= AC97Sync;
            shift_q        <= shift_next[18:0];
            tag_v_q        <= tag_v_d;
            addr_lat_q     <= addr_lat_d;
            slot3_lat_q    <= slot3_lat_d;
            codec_ready_q  <= codec_ready_d;
            status_addr_q  <= status_addr_d;
            status_data_q  <= status_data_d;
            status_valid_q <= status_valid_d;
            pcm_left_q     <= pcm_left_d;
            pcm_right_q    <= pcm_right_d;
            pcm_valid_q    <= pcm_valid_d;
            frame_done_q   <= frame_done_d;
            sync_error_q   <= sync_error_d;
        end
    end

    assign CodecReady  = codec_ready_q;
    assign StatusAddr  = status_addr_q;
    assign StatusData  = status_data_q;
    assign StatusValid = status_valid_q;
    assign PcmLeft     = pcm_left_q;
    assign PcmRight    = pcm_right_q;
    assign PcmValid    = pcm_valid_q;
    assign FrameDone   = frame_done_q;
    assign SyncError   = sync_error_q;

endmodule

// File: tb/tb_ac97_sdi_receiver.sv
// tb_ac97_sdi_receiver
//
// Drives whole AC97 frames (built as 256-bit vectors from slot values) into
// ac97_sdi_receiver and compares outputs and pulse timing against a
// frame-level reference model.
module tb_ac97_sdi_receiver;

    localparam int PcmW = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sdi;
    logic            sync;
    logic            codec_ready;
    logic [6:0]      status_addr;
    logic [15:0]     status_data;
    logic            status_valid;
    logic [PcmW-1:0] pcm_left;
    logic [PcmW-1:0] pcm_right;
    logic            pcm_valid;
    logic            frame_done;
    logic            sync_error;

    ac97_sdi_receiver #(
        .PCM_WIDTH      (PcmW),
        .SYNC_HIGH_BITS (16)
    ) dut (
        .AC97BitClock (clk),
        .Rst_n        (rst_n),
        .AC97SDI      (sdi),
        .AC97Sync     (sync),
        .CodecReady   (codec_ready),
        .StatusAddr   (status_addr),
        .StatusData   (status_data),
        .StatusValid  (status_valid),
        .PcmLeft      (pcm_left),
        .PcmRight     (pcm_right),
        .PcmValid     (pcm_valid),
        .FrameDone    (frame_done),
        .SyncError    (sync_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: attributes each output pulse to the frame bit index that
    // was sampled on the edge producing it.
    int cur_idx = -1;
    int cyc     = 0;
    int edge_idx;
    int sv_cnt = 0, pv_cnt = 0, fd_cnt = 0, se_cnt = 0;
    int sv_idx = -1, pv_idx = -1, fd_idx = -1, se_idx = -1;
    int fd_cyc[$];

    always @(posedge clk) begin
        edge_idx = cur_idx;
        cyc++;
        #1;
        if (status_valid) begin sv_cnt++; sv_idx = edge_idx; end
        if (pcm_valid)    begin pv_cnt++; pv_idx = edge_idx; end
        if (frame_done)   begin fd_cnt++; fd_idx = edge_idx; fd_cyc.push_back(cyc); end
        if (sync_error)   begin se_cnt++; se_idx = edge_idx; end
    end

    int b_sv, b_pv, b_fd, b_se;

    task automatic snap();
        b_sv = sv_cnt; b_pv = pv_cnt; b_fd = fd_cnt; b_se = se_cnt;
    endtask

    // Reference model state.
    logic            m_ready;
    logic [6:0]      m_addr;
    logic [15:0]     m_data;
    logic [PcmW-1:0] m_left;
    logic [PcmW-1:0] m_right;

    task automatic model_reset();
        m_ready = 1'b0; m_addr = '0; m_data = '0; m_left = '0; m_right = '0;
    endtask

    // Applies a frame whose first `len` bits arrived with correct alignment.
    task automatic model_frame(input logic [255:0] f, input int len,
                               output int e_sv, output int e_pv, output int e_fd);
        logic [15:0] tag;
        logic [19:0] s1, s2, s3, s4;
        tag = f[255:240]; s1 = f[239:220]; s2 = f[219:200];
        s3 = f[199:180];  s4 = f[179:160];
        e_sv = 0; e_pv = 0; e_fd = 0;
        if (len > 15) m_ready = tag[15];
        if (len > 55 && tag[15] && tag[14] && tag[13]) begin
            m_addr = s1[18:12]; m_data = s2[19:4]; e_sv = 1;
        end
        if (len > 95) begin
            if (tag[15] && tag[12]) begin m_left  = s3[19 -: PcmW]; e_pv = 1; end
            if (tag[15] && tag[11]) begin m_right = s4[19 -: PcmW]; e_pv = 1; end
        end
        if (len > 255) e_fd = 1;
    endtask

    function automatic logic [255:0] mkframe(input logic [15:0] tag, input logic [19:0] s1,
                                             input logic [19:0] s2, input logic [19:0] s3,
                                             input logic [19:0] s4);
        logic [159:0] rest;
        rest = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return {tag, s1, s2, s3, s4, rest};
    endfunction

    function automatic logic [15:0] rand_tag();
        logic [15:0] t;
        t = 16'($urandom());
        if ($urandom_range(0, 3) != 0) t[15] = 1'b1;
        return t;
    endfunction

    // Drives nbits of a frame; sync is high for bits 0..15 unless dropped at drop_at.
    task automatic send_frame(input logic [255:0] f, input int nbits, input int drop_at);
        snap();
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sdi     = f[255-i];
            sync    = (i < 16) && (drop_at < 0 || i < drop_at);
            cur_idx = i;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        snap();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sdi     = 1'($urandom_range(0, 1));
            sync    = 1'b0;
            cur_idx = 256 + k;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic expect_pulses(input string name, input int e_sv, input int e_pv,
                                 input int e_fd, input int e_se, input int e_se_idx);
        check_eq({name, ".sv_cnt"}, sv_cnt - b_sv, e_sv);
        if (e_sv == 1 && sv_cnt - b_sv == 1) check_eq({name, ".sv_idx"}, sv_idx, 55);
        check_eq({name, ".pv_cnt"}, pv_cnt - b_pv, e_pv);
        if (e_pv == 1 && pv_cnt - b_pv == 1) check_eq({name, ".pv_idx"}, pv_idx, 95);
        check_eq({name, ".fd_cnt"}, fd_cnt - b_fd, e_fd);
        if (e_fd == 1 && fd_cnt - b_fd == 1) check_eq({name, ".fd_idx"}, fd_idx, 255);
        check_eq({name, ".se_cnt"}, se_cnt - b_se, e_se);
        if (e_se == 1 && se_cnt - b_se == 1) check_eq({name, ".se_idx"}, se_idx, e_se_idx);
    endtask

    task automatic check_outputs(input string name);
        check_eq({name, ".ready"}, 32'(codec_ready), 32'(m_ready));
        check_eq({name, ".addr"},  32'(status_addr), 32'(m_addr));
        check_eq({name, ".data"},  32'(status_data), 32'(m_data));
        check_eq({name, ".left"},  32'(pcm_left),    32'(m_left));
        check_eq({name, ".right"}, 32'(pcm_right),   32'(m_right));
    endtask

    task automatic run_frame(input string name, input logic [255:0] f,
                             input int e_se, input int e_se_idx);
        int e_sv, e_pv, e_fd;
        send_frame(f, 256, -1);
        model_frame(f, 256, e_sv, e_pv, e_fd);
        expect_pulses(name, e_sv, e_pv, e_fd, e_se, e_se_idx);
        check_outputs(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] f;
        int e_sv, e_pv, e_fd;
        int q0;

        rst_n = 1'b0; sdi = 1'b0; sync = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        check_eq("reset.pulses", 32'({status_valid, pcm_valid, frame_done, sync_error}), 0);

        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        expect_pulses("idle", 0, 0, 0, 0, 0);
        check_outputs("idle");

        // Status frame.
        f = mkframe(16'hE000, {1'b0, 7'h26, 12'h000}, {16'h000F, 4'h0},
                    20'($urandom()), 20'($urandom()));
        run_frame("status", f, 0, 0);

        // PCM frames, back-to-back.
        f = mkframe(16'h9800, 20'($urandom()), 20'($urandom()), 20'h12345, 20'hABCDE);
        run_frame("pcm_lr", f, 0, 0);
        f = mkframe(16'h9000, 20'($urandom()), 20'($urandom()),
                    20'($urandom()), 20'($urandom()));
        run_frame("pcm_l", f, 0, 0);
        check_eq("pcm_l.right_hold", 32'(pcm_right), 32'h000ABCDE);

        // Invalid status slot.
        f = mkframe(16'hC000, {1'b0, 7'h11, 12'h000}, {16'h1234, 4'h0},
                    20'($urandom()), 20'($urandom()));
        run_frame("inv_status", f, 0, 0);
        check_eq("inv_status.data_hold", 32'(status_data), 32'h0000000F);

        // Sync drops at bit 8.
        f = mkframe(16'hF800, 20'($urandom()), 20'($urandom()),
                    20'($urandom()), 20'($urandom()));
        send_frame(f, 256, 8);
        model_frame(f, 8, e_sv, e_pv, e_fd);
        expect_pulses("drop8", e_sv, e_pv, e_fd, 1, 8);
        check_outputs("drop8");

        // Early sync rise at bit 100 aborts the frame; the new one decodes.
        f = mkframe(rand_tag(), 20'($urandom()), 20'($urandom()),
                    20'($urandom()), 20'($urandom()));
        send_frame(f, 100, -1);
        model_frame(f, 100, e_sv, e_pv, e_fd);
        expect_pulses("abort100", e_sv, e_pv, e_fd, 0, 0);
        f = mkframe(16'hF800, 20'($urandom()), 20'($urandom()),
                    20'($urandom()), 20'($urandom()));
        run_frame("after_abort", f, 1, 0);

        // Randomized back-to-back frames.
        for (int n = 0; n < 8; n++) begin
            f = mkframe(rand_tag(), 20'($urandom()), 20'($urandom()),
                        20'($urandom()), 20'($urandom()));
            run_frame($sformatf("rand%0d", n), f, 0, 0);
        end

        // No sync rise after bit 255.
        idle(10);
        expect_pulses("gap", 0, 0, 0, 1, 256);
        f = mkframe(rand_tag(), 20'($urandom()), 20'($urandom()),
                    20'($urandom()), 20'($urandom()));
        run_frame("after_gap", f, 0, 0);

        // Reset mid-frame at bit 40, then three back-to-back frames.
        f = mkframe(16'hF800, 20'($urandom()), 20'($urandom()),
                    20'($urandom()), 20'($urandom()));
        send_frame(f, 41, -1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        check_eq("midrst.pulses", 32'({status_valid, pcm_valid, frame_done, sync_error}), 0);
        @(negedge clk);
        sync    = 1'b0;
        sdi     = 1'b0;
        cur_idx = -1;
        rst_n   = 1'b1;
        q0 = fd_cyc.size();
        for (int n = 0; n < 3; n++) begin
            f = mkframe(rand_tag(), 20'($urandom()), 20'($urandom()),
                        20'($urandom()), 20'($urandom()));
            run_frame($sformatf("b2b%0d", n), f, 0, 0);
        end
        check_eq("b2b.fd_total", fd_cyc.size() - q0, 3);
        if (fd_cyc.size() - q0 == 3) begin
            check_eq("b2b.gap01", fd_cyc[q0+1] - fd_cyc[q0], 256);
            check_eq("b2b.gap12", fd_cyc[q0+2] - fd_cyc[q0+1], 256);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
